// File: rtl/ps2_scancode_asm.sv
// rtl/ps2_scancode_asm.sv - PS/2 Set-2 scancode byte assembler producing 16-bit key events
module ps2_scancode_asm #(
  parameter int TIMEOUT = 50000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  input  logic        i_err,
  output logic [15:0] o_key,
  output logic        o_make,
  output logic        o_valid,
  output logic        o_err,
  output logic        o_busy
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  // The watchdog fires on the idle cycle that would bring the count to TIMEOUT.
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_EXT     = 3'd1;
  localparam logic [2:0] S_BRK     = 3'd2;
  localparam logic [2:0] S_EXT_BRK = 3'd3;
  localparam logic [2:0] S_PAUSE   = 3'd4;

  // The Pause sequence is E1 followed by seven tail bytes; the seventh one
  // arrives while the count still reads six.
  localparam logic [2:0] PAUSE_LAST = 3'd6;

  logic [2:0]     r_state;
  logic [2:0]     r_pcnt;
  logic [WDW-1:0] r_wdog;
  logic [15:0]    r_key;
  logic           r_make;
  logic           r_valid;
  logic           r_err;
  logic           r_busy;

  logic [2:0]     w_state;
  logic [2:0]     w_pcnt;
  logic [WDW-1:0] w_wdog;
  logic           w_emit;
  logic [15:0]    w_key;
  logic           w_make;
  logic           w_abort;
  logic           w_is_prefix;
  logic           w_is_ctrl;
  logic           w_is_bad;

  assign w_is_prefix = (i_data == 8'he0) || (i_data == 8'hf0) || (i_data == 8'he1);
  assign w_is_ctrl   = (i_data == 8'haa) || (i_data == 8'hfa) ||
                       (i_data == 8'hfe) || (i_data == 8'hee);
  assign w_is_bad    = (i_data == 8'h00) || (i_data == 8'hff);

  // Next-state decode; a byte error always wins over a byte in the same cycle.
  always_comb begin
    w_state = r_state;
    w_pcnt  = r_pcnt;
    w_emit  = 1'b0;
    w_key   = r_key;
    w_make  = r_make;
    w_abort = 1'b0;
    if (i_err) begin
      w_abort = 1'b1;
      w_state = S_IDLE;
      w_pcnt  = 3'd0;
    end else if (i_valid) begin
      case (r_state)
        S_IDLE: begin
          if (i_data == 8'he0) begin
            w_state = S_EXT;
          end else if (i_data == 8'hf0) begin
            w_state = S_BRK;
          end else if (i_data == 8'he1) begin
            w_state = S_PAUSE;
            w_pcnt  = 3'd0;
          end else if (w_is_ctrl) begin
            w_state = S_IDLE;
          end else if (w_is_bad) begin
            w_abort = 1'b1;
          end else begin
            w_emit = 1'b1;
            w_key  = {8'h00, i_data};
            w_make = 1'b1;
          end
        end
        S_EXT: begin
          if (i_data == 8'hf0) begin
            w_state = S_EXT_BRK;
          end else if (i_data == 8'he0) begin
            w_state = S_EXT;
          end else if (i_data == 8'he1) begin
            w_abort = 1'b1;
            w_state = S_PAUSE;
            w_pcnt  = 3'd0;
          end else begin
            w_emit  = 1'b1;
            w_key   = {8'he0, i_data};
            w_make  = 1'b1;
            w_state = S_IDLE;
          end
        end
        S_BRK: begin
          if (i_data == 8'hf0) begin
            w_state = S_BRK;
          end else if (i_data == 8'he0) begin
            w_abort = 1'b1;
            w_state = S_EXT;
          end else if (i_data == 8'he1) begin
            w_abort = 1'b1;
            w_state = S_PAUSE;
            w_pcnt  = 3'd0;
          end else begin
            w_emit  = 1'b1;
            w_key   = {8'h00, i_data};
            w_make  = 1'b0;
            w_state = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if (w_is_prefix) begin
            w_abort = 1'b1;
          end else begin
            w_emit = 1'b1;
            w_key  = {8'he0, i_data};
            w_make = 1'b0;
          end
          w_state = S_IDLE;
        end
        S_PAUSE: begin
          if (r_pcnt == PAUSE_LAST) begin
            w_emit  = 1'b1;
            w_key   = 16'h00e1;
            w_make  = 1'b1;
            w_state = S_IDLE;
            w_pcnt  = 3'd0;
          end else begin
            w_pcnt = r_pcnt + 3'd1;
          end
        end
        default: begin
          w_state = S_IDLE;
          w_pcnt  = 3'd0;
        end
      endcase
    end else if ((r_state != S_IDLE) && (r_wdog == WD_LAST)) begin
      w_abort = 1'b1;
      w_state = S_IDLE;
      w_pcnt  = 3'd0;
    end
  end

  // Watchdog restarts on every accepted byte and rests at zero in IDLE.
  always_comb begin
    w_wdog = '0;
    if ((w_state != S_IDLE) && !i_valid) begin
      w_wdog = r_wdog + 1'b1;
    end
  end

  // Register state, counters and all outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_pcnt  <= 3'd0;
      r_wdog  <= '0;
      r_key   <= 16'h0000;
      r_make  <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pcnt  <= w_pcnt;
      r_wdog  <= w_wdog;
      r_valid <= w_emit;
      r_err   <= w_abort;
      r_busy  <= (w_state != S_IDLE);
      if (w_emit) begin
        r_key  <= w_key;
        r_make <= w_make;
      end
    end
  end

  assign o_key   = r_key;
  assign o_make  = r_make;
  assign o_valid = r_valid;
  assign o_err   = r_err;
  assign o_busy  = r_busy;

endmodule

// File: tb/tb_ps2_scancode_asm.sv
// tb/tb_ps2_scancode_asm.sv - self-checking bench for ps2_scancode_asm
module tb_ps2_scancode_asm;

  localparam int TO = 8;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data;
  logic        valid;
  logic        err;
  logic [15:0] key;
  logic        make;
  logic        ovalid;
  logic        oerr;
  logic        busy;

  ps2_scancode_asm #(.TIMEOUT(TO)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  (data),
    .i_valid (valid),
    .i_err   (err),
    .o_key   (key),
    .o_make  (make),
    .o_valid (ovalid),
    .o_err   (oerr),
    .o_busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_valid = 0;
  int n_err = 0;

  // Model: which prefixes have been seen, Pause tail progress, idle time.
  bit          m_ext, m_brk, m_pause;
  int          m_tail, m_idle;
  logic [15:0] e_key;
  logic        e_make, e_valid, e_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    m_ext = 0; m_brk = 0; m_pause = 0; m_tail = 0; m_idle = 0;
  endtask

  task automatic m_reset();
    m_clear();
    e_key = 16'h0000; e_make = 0; e_valid = 0; e_err = 0;
  endtask

  task automatic m_emit(input logic [15:0] k, input logic mk);
    e_key = k; e_make = mk; e_valid = 1; m_clear();
  endtask

  task automatic m_step(input logic v, input logic e, input logic [7:0] d);
    e_valid = 0; e_err = 0;
    if (e) begin
      e_err = 1; m_clear();
    end else if (v) begin
      m_idle = 0;
      if (m_pause) begin
        m_tail++;
        if (m_tail == 7) m_emit(16'h00e1, 1'b1);
      end else if (d == 8'he0) begin
        if (m_brk) begin
          e_err = 1;
          if (m_ext) m_clear();
          else begin m_brk = 0; m_ext = 1; end
        end else m_ext = 1;
      end else if (d == 8'hf0) begin
        if (m_ext && m_brk) begin e_err = 1; m_clear(); end
        else m_brk = 1;
      end else if (d == 8'he1) begin
        if (m_ext && m_brk) begin e_err = 1; m_clear(); end
        else begin
          if (m_ext || m_brk) e_err = 1;
          m_clear(); m_pause = 1;
        end
      end else if (m_ext || m_brk) begin
        m_emit({(m_ext ? 8'he0 : 8'h00), d}, !m_brk);
      end else if (d == 8'haa || d == 8'hfa || d == 8'hfe || d == 8'hee) begin
        // control bytes produce nothing
      end else if (d == 8'h00 || d == 8'hff) begin
        e_err = 1;
      end else begin
        m_emit({8'h00, d}, 1'b1);
      end
    end else if (m_ext || m_brk || m_pause) begin
      m_idle++;
      if (m_idle == TO) begin e_err = 1; m_clear(); end
    end
  endtask

  task automatic compare_all();
    chk("o_valid", 32'(ovalid), 32'(e_valid));
    chk("o_err", 32'(oerr), 32'(e_err));
    chk("o_busy", 32'(busy), 32'(m_ext || m_brk || m_pause));
    chk("o_key", 32'(key), 32'(e_key));
    chk("o_make", 32'(make), 32'(e_make));
    if (ovalid) n_valid++;
    if (oerr) n_err++;
  endtask

  task automatic step(input logic v, input logic e, input logic [7:0] d);
    @(negedge clk);
    valid = v; err = e; data = d;
    @(posedge clk);
    m_step(v, e, d);
    #1;
    compare_all();
    valid = 0; err = 0;
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, 1'b0, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_key"}, 32'(key), 32'h0);
    chk({tag, "_make"}, 32'(make), 32'h0);
    chk({tag, "_valid"}, 32'(ovalid), 32'h0);
    chk({tag, "_err"}, 32'(oerr), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  int v0, e0;

  initial begin
    rst_n = 0; valid = 0; err = 0; data = 8'h00;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1;

    // Plain make code
    send(8'h1c);
    chk("plain_key", 32'(key), 32'h001c);
    chk("plain_make", 32'(make), 32'h1);
    chk("plain_valid", 32'(ovalid), 32'h1);
    idle(2);

    // Extended break, busy between bytes
    v0 = n_valid;
    send(8'he0);
    chk("ext_busy", 32'(busy), 32'h1);
    send(8'hf0);
    chk("ext_nov", 32'(n_valid - v0), 32'h0);
    send(8'h75);
    chk("extbrk_key", 32'(key), 32'h0000e075);
    chk("extbrk_make", 32'(make), 32'h0);
    idle(2);
    chk("extbrk_cnt", 32'(n_valid - v0), 32'h1);

    // Pause sequence
    v0 = n_valid;
    send(8'he1); send(8'h14); send(8'h77); send(8'he1);
    send(8'hf0); send(8'h14); send(8'hf0); send(8'h77);
    chk("pause_key", 32'(key), 32'h000000e1);
    chk("pause_make", 32'(make), 32'h1);
    idle(2);
    chk("pause_cnt", 32'(n_valid - v0), 32'h1);

    // Watchdog expiry
    e0 = n_err;
    send(8'hf0);
    idle(TO);
    chk("to_err", 32'(oerr), 32'h1);
    chk("to_busy", 32'(busy), 32'h0);
    chk("to_cnt", 32'(n_err - e0), 32'h1);
    send(8'h1c);
    chk("to_next_key", 32'(key), 32'h001c);
    chk("to_next_make", 32'(make), 32'h1);

    // Byte arriving on the expiry cycle wins
    e0 = n_err;
    send(8'hf0);
    idle(TO - 1);
    send(8'h75);
    chk("to_race_key", 32'(key), 32'h0075);
    chk("to_race_make", 32'(make), 32'h0);
    idle(TO + 2);
    chk("to_race_noerr", 32'(n_err - e0), 32'h0);

    // Error with simultaneous byte
    v0 = n_valid; e0 = n_err;
    send(8'he0);
    step(1'b1, 1'b1, 8'h14);
    chk("errwin_err", 32'(oerr), 32'h1);
    chk("errwin_nov", 32'(n_valid - v0), 32'h0);
    send(8'h14);
    chk("errwin_key", 32'(key), 32'h0014);

    // Duplicate E0, E0 then E1, BRK then E0
    send(8'he0); send(8'he0); send(8'h14);
    chk("dup_e0_key", 32'(key), 32'h0000e014);
    e0 = n_err;
    send(8'he0); send(8'he1);
    for (int i = 0; i < 7; i++) send(8'(8'h20 + i));
    chk("e0e1_key", 32'(key), 32'h000000e1);
    send(8'hf0); send(8'he0); send(8'h6b);
    chk("brk_e0_key", 32'(key), 32'h0000e06b);
    chk("brk_e0_make", 32'(make), 32'h1);
    chk("misc_errs", 32'(n_err - e0), 32'h2);

    // Control bytes and bad byte
    v0 = n_valid; e0 = n_err;
    send(8'haa); send(8'hfa);
    chk("ctrl_nov", 32'(n_valid - v0), 32'h0);
    chk("ctrl_noerr", 32'(n_err - e0), 32'h0);
    send(8'h00);
    chk("bad_err", 32'(oerr), 32'h1);
    idle(1);

    // Reset during EXT
    send(8'he0);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk_reset_outputs("midrst");
    m_reset();
    @(negedge clk);
    #1;
    chk_reset_outputs("midrst2");
    rst_n = 1;
    send(8'h5a);
    chk("postrst_key", 32'(key), 32'h005a);
    chk("postrst_make", 32'(make), 32'h1);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
